ub_skew_read_sequencer: RTL and testbench
=========================================

// Module: ub_skew_read_sequencer
// PURPOSE
// Sequences tile reads out of port one of the unified buffer for the systolic array input edge.
// One Start command reads NumRows consecutive rows from BaseAddress in every bank.
// Each bank is skewed one cycle after the previous bank (diagonal wavefront), so row data needs no external delay line.
// Drives the UB PortOneReadValid/PortOneReadAddress arrays and emits per-bank DataValid aligned with PortOneReadData.
// PARAMETERS
// NUM_BANKS   16    number of UB banks / systolic rows; >= 1
// BANK_DEPTH  4096  rows per bank; must be a power of two
// ROW_BITS    $clog2(BANK_DEPTH)  localparam, row address width
// PORTS
// CLK               in   1              clock, rising edge
// ASYNC_RST         in   1              asynchronous reset, active low
// SYNC_RST          in   1              synchronous reset, active high, qualified by EN
// EN                in   1              global enable; 0 freezes all state and outputs
// Start             in   1              command strobe, accepted only in IDLE
// BaseAddress       in   ROW_BITS       first row of tile, sampled on accepted Start
// NumRows           in   ROW_BITS+1     rows per bank, 0..BANK_DEPTH, sampled on accepted Start
// Stall             in   1              downstream hold; freezes the wavefront
// Busy              out  1              command in progress (RUN or FLUSH)
// Done              out  1              one-cycle pulse at command completion
// ReadValid         out  1 [NUM_BANKS]  to UB PortOneReadValid
// ReadAddress       out  ROW_BITS [NUM_BANKS]  to UB PortOneReadAddress
// DataValid         out  1 [NUM_BANKS]  PortOneReadData[b] holds a new tile row this cycle
// BEHAVIOUR
// - Reset (async or EN&SYNC_RST): state IDLE, counter 0, Busy/Done/ReadValid/DataValid 0, ReadAddress 0.
// - All registers update only when EN=1; SYNC_RST has priority over every other action.
// - FSM: IDLE -> RUN on Start with NumRows>0; IDLE -> IDLE with Done=1 next cycle on Start with NumRows==0 (no reads).
// - RUN: wavefront counter C starts at 0. In a non-stalled RUN cycle, bank b asserts ReadValid when b <= C < b+NumRows.
//   ReadAddress[b] = (BaseAddress + C - b) mod BANK_DEPTH in that cycle. C increments by 1.
// - RUN -> FLUSH after the non-stalled cycle with C == NumRows+NUM_BANKS-2; FLUSH lasts 1 cycle; FLUSH -> IDLE with Done=1.
// - ReadValid/ReadAddress are registered outputs: the command accepted at edge k drives bank 0 row 0 after edge k+1.
// - Stall=1 in RUN: all ReadValid 0, C holds, ReadAddress holds; resume continues exactly where it stopped.
// - Stall has no effect in IDLE or FLUSH.
// - DataValid[b] = ReadValid[b] delayed one EN-qualified cycle (UB read latency 1); never gated by Stall.
// - Start while Busy: ignored; no queueing. Start in the same cycle as Done: accepted (state is IDLE).
// - Busy=1 from the cycle after an accepted Start through the FLUSH cycle inclusive; Done and Busy are never both 1.
// - Read issue: exactly NumRows reads per bank, with no gaps other than stalls.
//   Non-stalled command length = NumRows+NUM_BANKS-1 RUN cycles + 1 FLUSH cycle.
// - Address wrap: rows past BANK_DEPTH-1 wrap to 0 (modulo arithmetic, ROW_BITS truncation).
//   NumRows==BANK_DEPTH reads every row once.
// - Internal C width: ROW_BITS+1+$clog2(NUM_BANKS+1); no overflow for any legal NumRows.
// - EN=0 mid-command: everything frozen incl. ReadValid level; the UB is also gated by EN, so no duplicate reads occur.
// - Async reset mid-command: command abandoned, no Done.
// TESTING
// (bench: NUM_BANKS=4, BANK_DEPTH=16, UB preloaded mem[b][r]=16*b+r)
// 1 Start, Base=2, NumRows=3, no stall
//   -> bank b ReadValid on RUN cycles b..b+2 with addresses 2,3,4; 6 RUN cycles + FLUSH; Done once.
//   -> DataValid[b] sequence of data 16b+2..16b+4.
// 2 Base=14, NumRows=4 -> bank0 addresses 14,15,0,1 (wrap); bank3 same, starting 3 cycles later.
// 3 Scenario 1 with Stall=1 for 2 cycles at C=2
//   -> no ReadValid during stall; addresses resume unchanged; total Busy = 9 cycles; no duplicate or missing rows.
// 4 Start with NumRows=0 -> Done pulse next cycle, Busy never 1, no ReadValid.
//   Start pulsed during Busy -> ignored; rows per bank still 3.
// 5 NumRows=16, Base=5 -> each bank reads all 16 rows exactly once (scoreboard); Done after 19+1 cycles.
// 6 ASYNC_RST low at C=3 -> all outputs 0 immediately; after release, a new Start runs cleanly.
//   EN=0 for 3 cycles mid-RUN -> outputs held, final read sequence identical to scenario 1.

Source files
------------

// File: rtl/ub_skew_read_sequencer.sv
// rtl/ub_skew_read_sequencer.sv - diagonal-wavefront tile read sequencer for unified buffer port one
// One command reads NumRows rows from every bank, each bank lagging the previous one by a cycle.
module ub_skew_read_sequencer #(
  parameter int NUM_BANKS  = 16,
  parameter int BANK_DEPTH = 4096,
  localparam int ROW_BITS  = $clog2(BANK_DEPTH)
) (
  input  logic                               i_clk,
  input  logic                               i_async_rst_n,
  input  logic                               i_sync_rst,
  input  logic                               i_en,
  input  logic                               i_start,
  input  logic [ROW_BITS-1:0]                i_base_address,
  input  logic [ROW_BITS:0]                  i_num_rows,
  input  logic                               i_stall,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [NUM_BANKS-1:0]               o_read_valid,
  output logic [NUM_BANKS-1:0][ROW_BITS-1:0] o_read_address,
  output logic [NUM_BANKS-1:0]               o_data_valid
);

  localparam int CW = ROW_BITS + 1 + $clog2(NUM_BANKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                             r_state, w_state_nxt;
  logic [CW-1:0]                      r_c, w_c_nxt;
  logic [ROW_BITS-1:0]                r_base, w_base_nxt;
  logic [ROW_BITS:0]                  r_num, w_num_nxt;
  logic                               r_done, w_done_nxt;
  logic [NUM_BANKS-1:0]               r_rv, w_rv_nxt;
  logic [NUM_BANKS-1:0][ROW_BITS-1:0] r_ra, w_ra_nxt;
  logic [NUM_BANKS-1:0]               r_dv;
  logic                               w_last;

  // Last wavefront position: the final bank issues its final row.
  assign w_last = (r_c == (CW'(r_num) + CW'(NUM_BANKS - 2)));

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_base_nxt  = r_base;
    w_num_nxt   = r_num;
    w_done_nxt  = 1'b0;
    w_rv_nxt    = '0;
    w_ra_nxt    = r_ra;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_num_rows == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_c_nxt     = '0;
            w_base_nxt  = i_base_address;
            w_num_nxt   = i_num_rows;
          end
        end
      end
      S_RUN: begin
        if (!i_stall) begin
          for (int b = 0; b < NUM_BANKS; b++) begin
            w_rv_nxt[b] = (r_c >= CW'(b)) && (r_c < (CW'(b) + CW'(r_num)));
            w_ra_nxt[b] = r_base + ROW_BITS'(r_c) - ROW_BITS'(b);
          end
          w_c_nxt = r_c + 1'b1;
          if (w_last) begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_base  <= '0;
      r_num   <= '0;
      r_done  <= 1'b0;
      r_rv    <= '0;
      r_ra    <= '0;
      r_dv    <= '0;
    end else if (i_en) begin
      if (i_sync_rst) begin
        r_state <= S_IDLE;
        r_c     <= '0;
        r_base  <= '0;
        r_num   <= '0;
        r_done  <= 1'b0;
        r_rv    <= '0;
        r_ra    <= '0;
        r_dv    <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_c     <= w_c_nxt;
        r_base  <= w_base_nxt;
        r_num   <= w_num_nxt;
        r_done  <= w_done_nxt;
        r_rv    <= w_rv_nxt;
        r_ra    <= w_ra_nxt;
        // UB read latency is one enabled cycle, so data lands one cycle after the request.
        r_dv    <= r_rv;
      end
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;
  assign o_read_valid   = r_rv;
  assign o_read_address = r_ra;
  assign o_data_valid   = r_dv;

endmodule

// File: tb/tb_ub_skew_read_sequencer.sv
// tb/tb_ub_skew_read_sequencer.sv - directed self-checking bench for ub_skew_read_sequencer
// Small UB model holds mem[b][r] = 16*b + r; a negedge monitor records reads and returned data.
module tb_ub_skew_read_sequencer;

  localparam int NB = 4;
  localparam int DEPTH = 16;
  localparam int RB = 4;

  logic              clk;
  logic              rst_n;
  logic              sync_rst;
  logic              en;
  logic              start;
  logic [RB-1:0]     base;
  logic [RB:0]       num;
  logic              stall;
  logic              busy;
  logic              done;
  logic [NB-1:0]     rv;
  logic [NB-1:0][RB-1:0] ra;
  logic [NB-1:0]     dv;

  int n_checks = 0;
  int n_fail   = 0;

  ub_skew_read_sequencer #(.NUM_BANKS(NB), .BANK_DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_async_rst_n  (rst_n),
    .i_sync_rst     (sync_rst),
    .i_en           (en),
    .i_start        (start),
    .i_base_address (base),
    .i_num_rows     (num),
    .i_stall        (stall),
    .o_busy         (busy),
    .o_done         (done),
    .o_read_valid   (rv),
    .o_read_address (ra),
    .o_data_valid   (dv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ub_q [NB];
  always @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < NB; b++) begin
        if (rv[b]) ub_q[b] <= 16 * b + int'(ra[b]);
      end
    end
  end

  logic mon_clr = 1'b0;
  int   rd_addr [NB][32];
  int   dv_data [NB][32];
  int   rd_cnt [NB];
  int   dv_cnt [NB];
  int   first_rd [NB];
  int   cyc, busy_cnt, done_cnt, overlap_cnt;

  always @(negedge clk) begin
    if (mon_clr) begin
      for (int b = 0; b < NB; b++) begin
        rd_cnt[b] = 0;
        dv_cnt[b] = 0;
        first_rd[b] = 0;
      end
      cyc = 0;
      busy_cnt = 0;
      done_cnt = 0;
      overlap_cnt = 0;
    end else begin
      if (en) cyc++;
      for (int b = 0; b < NB; b++) begin
        if (en && rv[b]) begin
          if (rd_cnt[b] == 0) first_rd[b] = cyc;
          if (rd_cnt[b] < 32) rd_addr[b][rd_cnt[b]] = int'(ra[b]);
          rd_cnt[b]++;
        end
        if (en && dv[b]) begin
          if (dv_cnt[b] < 32) dv_data[b][dv_cnt[b]] = ub_q[b];
          dv_cnt[b]++;
        end
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (done && busy) overlap_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input int b_addr, input int rows, input int stall_at, input int stall_len,
                         input int en_at, input int en_len, input int spulse_at);
    bit got_done = 1'b0;
    @(posedge clk); #1;
    mon_clr = 1'b1;
    start = 1'b1;
    base = RB'(b_addr);
    num = (RB+1)'(rows);
    @(posedge clk); #1;
    mon_clr = 1'b0;
    start = 1'b0;
    num = 5'd7;
    for (int j = 0; j < 200; j++) begin
      stall = (j >= stall_at) && (j < stall_at + stall_len);
      en = !((j >= en_at) && (j < en_at + en_len));
      start = (j == spulse_at);
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    en = 1'b1;
    start = 1'b0;
    if (!got_done) check("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cmd(input string nm, input int b_addr, input int rows, input int busy_exp,
                           input bit skew_chk);
    for (int b = 0; b < NB; b++) begin
      check({nm, "_rd_cnt"}, rd_cnt[b], rows);
      check({nm, "_dv_cnt"}, dv_cnt[b], rows);
      for (int i = 0; i < rows && i < 32; i++) begin
        check({nm, "_addr"}, rd_addr[b][i], (b_addr + i) % DEPTH);
        check({nm, "_data"}, dv_data[b][i], 16 * b + (b_addr + i) % DEPTH);
      end
      if (skew_chk && rows > 0) check({nm, "_skew"}, first_rd[b] - first_rd[0], b);
    end
    check({nm, "_busy_cycles"}, busy_cnt, busy_exp);
    check({nm, "_done_cnt"}, done_cnt, 1);
    check({nm, "_done_busy_overlap"}, overlap_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    sync_rst = 1'b0;
    en = 1'b1;
    start = 1'b0;
    base = '0;
    num = '0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rv", rv, 0);
    check("rst_dv", dv, 0);
    check("rst_ra", ra, 0);
    rst_n = 1'b1;

    run_cmd(2, 3, -1, 0, -1, 0, -1);
    check_cmd("s1", 2, 3, 7, 1'b1);

    run_cmd(14, 4, -1, 0, -1, 0, -1);
    check_cmd("s2_wrap", 14, 4, 8, 1'b1);

    run_cmd(2, 3, 2, 2, -1, 0, -1);
    check_cmd("s3_stall", 2, 3, 9, 1'b0);

    run_cmd(9, 0, -1, 0, -1, 0, -1);
    check_cmd("s4_zero", 9, 0, 0, 1'b0);

    run_cmd(2, 3, -1, 0, -1, 0, 3);
    check_cmd("s4_start_busy", 2, 3, 7, 1'b1);

    run_cmd(5, 16, -1, 0, -1, 0, -1);
    check_cmd("s5_full", 5, 16, 20, 1'b1);

    // Async reset while the wavefront is at C=3.
    @(posedge clk); #1;
    mon_clr = 1'b1;
    start = 1'b1;
    base = 4'd2;
    num = 5'd3;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_arst_rv", rv, 4'b0111);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rv", rv, 0);
    check("arst_dv", dv, 0);
    check("arst_ra", ra, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_no_done", done_cnt, 0);

    run_cmd(2, 3, -1, 0, -1, 0, -1);
    check_cmd("s6_after_arst", 2, 3, 7, 1'b1);

    // Synchronous reset mid-run.
    @(posedge clk); #1;
    mon_clr = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sync_rst = 1'b1;
    @(posedge clk); #1;
    sync_rst = 1'b0;
    check("srst_busy", busy, 0);
    check("srst_rv", rv, 0);
    repeat (4) @(negedge clk);
    check("srst_no_done", done_cnt, 0);

    run_cmd(2, 3, -1, 0, 2, 3, -1);
    check_cmd("s6_en_gap", 2, 3, 10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
